// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: arbiter state encodings, access size codes and bus widths
package ram_arbiter_pkg;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    typedef enum logic [1:0] {IDLE = 2'b00, BUSY_IF = 2'b01, BUSY_LS = 2'b10} state_t;
    localparam logic [2:0] SIZE_B = 3'b000;
    localparam logic [2:0] SIZE_H = 3'b001;
    localparam logic [2:0] SIZE_W = 3'b010;
    localparam logic [2:0] SIZE_D = 3'b011;
endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: valid/ready memory request bus shared by fetch, load/store and memory sides
interface ram_arbiter_if;
    import ram_arbiter_pkg::*;
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic              wen;
    logic [DATA_W-1:0] wdata;
    logic [2:0]        size;
    logic              ready;
    logic [DATA_W-1:0] rdata;
    modport master (output valid, addr, wen, wdata, size, input ready, rdata);
    modport slave  (input valid, addr, wen, wdata, size, output ready, rdata);
    // instruction fetch is read-only, so it carries no write fields
    modport fetch  (input valid, addr, size, output ready, rdata);
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: single-port RAM arbiter between fetch and load/store, LSU-first with fetch starvation guard
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input logic           clk,
    input logic           rst,
    ram_arbiter_if.fetch  if_bus,
    ram_arbiter_if.slave  ls_bus,
    ram_arbiter_if.master mem_bus
);
    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);
    state_t            state_q, state_d;
    logic [2:0]        streak_q;
    logic              busy, gnt_if, gnt_ls, done_if, done_ls;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              wen_q;
    logic [2:0]        size_q;
    always_comb begin
        busy    = state_q == BUSY_IF || state_q == BUSY_LS;
        gnt_if  = state_q == IDLE && if_bus.valid && (!ls_bus.valid || streak_q == LIMIT);
        gnt_ls  = state_q == IDLE && ls_bus.valid && !gnt_if;
        done_if = state_q == BUSY_IF && mem_bus.ready;
        done_ls = state_q == BUSY_LS && mem_bus.ready;
        // the unused encoding falls through to IDLE since it is neither busy nor granting
        state_d = gnt_if ? BUSY_IF : gnt_ls ? BUSY_LS : busy && !mem_bus.ready ? state_q : IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= gnt_if ? 3'd0 : gnt_ls && if_bus.valid && streak_q < LIMIT ? streak_q + 3'd1 : streak_q;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            size_q  <= '0;
        end else if (gnt_if) begin
            addr_q  <= if_bus.addr;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            size_q  <= if_bus.size;
        end else if (gnt_ls) begin
            addr_q  <= ls_bus.addr;
            wdata_q <= ls_bus.wdata;
            wen_q   <= ls_bus.wen;
            size_q  <= ls_bus.size;
        end
    end
    assign mem_bus.valid = busy;
    assign mem_bus.addr  = addr_q;
    assign mem_bus.wen   = wen_q;
    assign mem_bus.wdata = wdata_q;
    assign mem_bus.size  = size_q;
    assign if_bus.ready  = done_if;
    assign if_bus.rdata  = done_if ? mem_bus.rdata : '0;
    assign ls_bus.ready  = done_ls;
    assign ls_bus.rdata  = done_ls ? mem_bus.rdata : '0;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed stimulus with a queue scoreboard popped by a negedge monitor on every ready pulse
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;
    typedef struct {
        bit          ls;
        logic [63:0] addr;
        bit          wen;
        logic [63:0] wdata;
        logic [2:0]  size;
        logic [63:0] rdata;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   ls_pulses = 0;
    int   if_pulses = 0;
    int   mv_cycles = 0;
    exp_t exp_q[$];
    ram_arbiter_if if_bus ();
    ram_arbiter_if ls_bus ();
    ram_arbiter_if mem_bus ();
    ram_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst), .if_bus(if_bus), .ls_bus(ls_bus), .mem_bus(mem_bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic push(input bit ls, input logic [63:0] addr, input bit wen, input logic [63:0] wdata,
                        input logic [2:0] size, input logic [63:0] rdata);
        exp_t e;
        e.ls = ls; e.addr = addr; e.wen = wen; e.wdata = wdata; e.size = size; e.rdata = rdata;
        exp_q.push_back(e);
    endtask
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_bus.valid) mv_cycles++;
            if (!if_bus.ready) chk("if_rdata_idle", if_bus.rdata, 64'd0);
            if (!ls_bus.ready) chk("ls_rdata_idle", ls_bus.rdata, 64'd0);
            if (if_bus.ready || ls_bus.ready) begin
                if (if_bus.ready) if_pulses++;
                if (ls_bus.ready) ls_pulses++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ready: got if=%b ls=%b expected none", if_bus.ready, ls_bus.ready);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("grant_is_ls", {63'd0, ls_bus.ready}, {63'd0, e.ls});
                    chk("grant_is_if", {63'd0, if_bus.ready}, {63'd0, !e.ls});
                    chk("mem_addr", mem_bus.addr, e.addr);
                    chk("mem_wen", {63'd0, mem_bus.wen}, {63'd0, e.wen});
                    chk("mem_wdata", mem_bus.wdata, e.wdata);
                    chk("mem_size", {61'd0, mem_bus.size}, {61'd0, e.size});
                    chk("rdata", e.ls ? ls_bus.rdata : if_bus.rdata, e.rdata);
                end
            end
        end
    end
    initial begin
        int base;
        if_bus.valid = 0; if_bus.addr = 0; if_bus.size = 0; if_bus.wen = 0; if_bus.wdata = 0;
        ls_bus.valid = 0; ls_bus.addr = 0; ls_bus.size = 0; ls_bus.wen = 0; ls_bus.wdata = 0;
        mem_bus.ready = 0; mem_bus.rdata = 0;
        #1 rst = 1;
        #2;
        chk("rst_mem_valid", {63'd0, mem_bus.valid}, 64'd0);
        chk("rst_mem_addr", mem_bus.addr, 64'd0);
        chk("rst_mem_wdata", mem_bus.wdata, 64'd0);
        chk("rst_ready", {62'd0, if_bus.ready, ls_bus.ready}, 64'd0);
        chk("rst_streak", {61'd0, dut.streak_q}, 64'd0);
        step();
        rst = 0;
        // LSU byte write, memory answers in the second busy cycle
        ls_bus.valid = 1; ls_bus.addr = 64'h8000_0010; ls_bus.wen = 1; ls_bus.wdata = 64'hAB; ls_bus.size = SIZE_B;
        mem_bus.rdata = 64'h55;
        push(1, 64'h8000_0010, 1, 64'hAB, SIZE_B, 64'h55);
        base = mv_cycles;
        step();
        chk("t1_mem_valid", {63'd0, mem_bus.valid}, 64'd1);
        chk("t1_ls_wait", {63'd0, ls_bus.ready}, 64'd0);
        step();
        mem_bus.ready = 1;
        step();
        ls_bus.valid = 0; mem_bus.ready = 0;
        step(); step();
        chk("t1_mem_valid_cycles", 64'(mv_cycles - base), 64'd2);
        chk("t1_ls_pulses", 64'(ls_pulses), 64'd1);
        // fetch completes in its first busy cycle
        if_bus.valid = 1; if_bus.addr = 64'h8000_0000; if_bus.size = SIZE_W;
        mem_bus.ready = 1; mem_bus.rdata = 64'h13;
        push(0, 64'h8000_0000, 0, 64'd0, SIZE_W, 64'h13);
        step();
        chk("t2_if_ready", {63'd0, if_bus.ready}, 64'd1);
        chk("t2_if_rdata", if_bus.rdata, 64'h13);
        step();
        if_bus.valid = 0;
        chk("t2_idle", {63'd0, mem_bus.valid}, 64'd0);
        step();
        mem_bus.ready = 0;
        // both requesters held: four contested LSU grants, then fetch is forced
        if_bus.valid = 1; if_bus.addr = 64'h1000; if_bus.size = SIZE_W;
        ls_bus.valid = 1; ls_bus.addr = 64'h2000; ls_bus.wen = 0; ls_bus.wdata = 64'h5; ls_bus.size = SIZE_H;
        mem_bus.ready = 1; mem_bus.rdata = 64'h77;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) push(0, 64'h1000, 0, 64'd0, SIZE_W, 64'h77);
            else push(1, 64'h2000, 0, 64'h5, SIZE_H, 64'h77);
        end
        for (int i = 1; i <= 12; i++) begin
            step();
            if (i == 9) chk("t3_streak_after_if", {61'd0, dut.streak_q}, 64'd0);
        end
        if_bus.valid = 0; ls_bus.valid = 0; mem_bus.ready = 0;
        chk("t3_streak_end", {61'd0, dut.streak_q}, 64'd1);
        step();
        // asynchronous reset during an LSU access abandons it
        ls_bus.valid = 1; ls_bus.addr = 64'h3000; ls_bus.size = SIZE_D;
        step();
        chk("t4_busy", {63'd0, mem_bus.valid}, 64'd1);
        #2 rst = 1;
        #1;
        chk("t4_async_mem_valid", {63'd0, mem_bus.valid}, 64'd0);
        chk("t4_async_mem_addr", mem_bus.addr, 64'd0);
        ls_bus.valid = 0; mem_bus.ready = 1;
        base = ls_pulses + if_pulses;
        step(); step();
        rst = 0;
        repeat (4) step();
        chk("t4_no_pulse", 64'(ls_pulses + if_pulses - base), 64'd0);
        // idle mem_ready ignored, mid-transaction field changes and valid drop ignored
        repeat (2) step();
        mem_bus.ready = 0;
        ls_bus.valid = 1; ls_bus.addr = 64'h4000; ls_bus.wen = 0; ls_bus.wdata = 64'h99; ls_bus.size = SIZE_D;
        mem_bus.rdata = 64'hCAFE;
        push(1, 64'h4000, 0, 64'h99, SIZE_D, 64'hCAFE);
        base = ls_pulses;
        step();
        ls_bus.addr = 64'hDEAD; ls_bus.valid = 0;
        step();
        chk("t5_addr_hold", mem_bus.addr, 64'h4000);
        mem_bus.ready = 1;
        step();
        mem_bus.ready = 0;
        step(); step();
        chk("t5_ls_pulse", 64'(ls_pulses - base), 64'd1);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
    initial begin
        #20000;
        $display("FAIL timeout: got no finish expected finish by 20000");
        $fatal(1);
    end
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive contested LSU grants before IF is forced.
REQ-002 SHALL have ports: clk input 1, clock (one clock); rst input 1, reset, asynchronous, active-high.
REQ-003 SHALL have IF requester ports: if_valid in 1 req; if_addr in 64; if_size in 3; if_ready out 1 done; if_rdata out 64.
REQ-004 SHALL have LSU requester ports: ls_valid in 1; ls_addr in 64; ls_wen in 1; ls_wdata in 64; ls_size in 3; ls_ready out 1; ls_rdata out 64.
REQ-005 SHALL have memory ports: mem_valid out 1; mem_addr out 64; mem_wen out 1; mem_wdata out 64; mem_size out 3; mem_ready in 1 (also rdata valid); mem_rdata in 64.

Function
REQ-006 SHALL implement states IDLE, BUSY_IF, BUSY_LS; encoding 2 bits, unused code -> IDLE.
REQ-007 IDLE: no valid -> IDLE; only ls_valid -> BUSY_LS; only if_valid -> BUSY_IF; both -> BUSY_LS unless streak == STARVE_LIMIT, then BUSY_IF.
REQ-008 On the IDLE->BUSY_x edge SHALL register the winner's addr, size, wen (0 for IF), wdata (0 for IF) into mem_* registers.
REQ-009 mem_valid SHALL be 1 exactly while in BUSY_IF or BUSY_LS; mem_* fields SHALL be stable throughout.
REQ-010 In BUSY_x with mem_ready=1: x_ready=1 and x_rdata=mem_rdata combinationally same cycle; next state IDLE.
REQ-011 In BUSY_x with mem_ready=0: remain BUSY_x; x_ready=0.
REQ-012 Non-granted requester's ready SHALL be 0; its rdata SHALL be 0; both rdata outputs SHALL be 0 outside their completion cycle.
REQ-013 mem_ready in IDLE SHALL be ignored (no ready pulse, no state change).
REQ-014 Latency: valid seen in IDLE at cycle T -> mem_valid at T+1 -> earliest x_ready at T+1; one IDLE bubble after each completion.
REQ-015 Requesters SHALL hold valid and fields until x_ready; arbiter does not re-sample after grant, so mid-transaction field changes are ignored.
REQ-016 Requester dropping valid after grant SHALL not abort the memory transaction; its ready pulse still occurs.
REQ-017 streak (3-bit, saturating at STARVE_LIMIT): +1 on an LSU grant while if_valid=1; cleared on any IF grant; unchanged on uncontested LSU grant.
REQ-018 Simultaneous completion and new requests: completion cycle returns to IDLE; arbitration uses valids seen in the following IDLE cycle.

Reset
REQ-019 rst=1 SHALL immediately (asynchronously) force state IDLE, streak 0, mem_valid 0, mem_addr 0, mem_wen 0, mem_wdata 0, mem_size 0, if_ready 0, ls_ready 0, rdata outputs 0.
REQ-020 Reset mid-transaction SHALL abandon the outstanding access; no ready pulse to either requester after release.
REQ-021 First arbitration SHALL occur in the first clk edge with rst=0.

Structure
REQ-022 State encodings (IDLE/BUSY_IF/BUSY_LS) and size codes (B=000, H=001, W=010, D=011) SHALL live in the shared defines package.
REQ-023 SHALL be a single module; no sub-modules; estimated 150-250 RTL lines.

Verification
REQ-024 ls_valid=1, ls_addr=0x8000_0010, wen=1, wdata=0xAB, size=000, mem_ready at 2nd BUSY cycle -> mem_valid 2 cycles, ls_ready 1 cycle, mem_wen=1.
REQ-025 if_valid=1, if_addr=0x8000_0000, mem_ready=1 immediately, mem_rdata=0x0000_0013 -> if_ready=1 and if_rdata=0x13 at T+1, IDLE at T+2.
REQ-026 Both valid held continuously, mem_ready always 1 -> grant order LS,LS,LS,LS,IF,LS... (STARVE_LIMIT=4), streak back to 0 after IF grant.
REQ-027 rst=1 asserted mid-BUSY_LS without clock edge -> mem_valid=0 immediately; after release with no valids, no ready pulse ever.
REQ-028 mem_ready pulsed while IDLE, and ls_addr changed to 0xDEAD during BUSY_LS -> no ready pulse; mem_addr keeps granted value.
